// File: rtl/xge_regif_pkg.sv
// Shared address map, version constant and timer width for the MAC Wishbone register block.
package xge_regif_pkg;

    localparam int unsigned HOLDOFF_W = 16;

    localparam logic [31:0] REG_CONFIG0     = 32'h0000_0000;
    localparam logic [31:0] REG_INT_PENDING = 32'h0000_0004;
    localparam logic [31:0] REG_INT_STATUS  = 32'h0000_0008;
    localparam logic [31:0] REG_INT_MASK    = 32'h0000_000C;
    localparam logic [31:0] REG_INT_EDGE    = 32'h0000_0010;
    localparam logic [31:0] REG_INT_HOLDOFF = 32'h0000_0014;
    localparam logic [31:0] REG_VERSION     = 32'h0000_0018;
    localparam logic [31:0] REG_STATS_BASE  = 32'h0000_0020;

    localparam logic [31:0] VERSION = 32'h0002_0000;

endpackage

// File: rtl/xge_int_ctrl.sv
// Interrupt event detection, write-1-to-clear pending register, holdoff timer and interrupt output.
module xge_int_ctrl
    import xge_regif_pkg::*;
#(
    parameter int unsigned NUM_INT = 10
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NUM_INT-1:0]   int_src_i,
    input  logic [NUM_INT-1:0]   int_mask,
    input  logic [NUM_INT-1:0]   int_edge,
    input  logic [HOLDOFF_W-1:0] int_holdoff,
    input  logic                 w1c_we,
    input  logic [NUM_INT-1:0]   w1c_data,
    output logic [NUM_INT-1:0]   int_pending,
    output logic [NUM_INT-1:0]   int_status,
    output logic                 wb_int_o
);

    logic [NUM_INT-1:0]   src_d1;
    logic [NUM_INT-1:0]   w1c;
    logic [NUM_INT-1:0]   pending_next;
    logic [HOLDOFF_W-1:0] holdoff_cnt;

    assign int_status   = (int_edge & (int_src_i ^ src_d1)) | (~int_edge & int_src_i);
    assign w1c          = w1c_we ? w1c_data : '0;
    // New events take priority over a clear landing in the same cycle.
    assign pending_next = (int_pending & ~w1c) | int_status;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            src_d1      <= '0;
            int_pending <= '0;
            holdoff_cnt <= '0;
            wb_int_o    <= 1'b0;
        end else begin
            src_d1      <= int_src_i;
            int_pending <= pending_next;
            if (|(w1c & int_pending))
                holdoff_cnt <= int_holdoff;
            else if (holdoff_cnt != '0)
                holdoff_cnt <= holdoff_cnt - HOLDOFF_W'(1);
            wb_int_o <= (|(int_pending & int_mask)) && (holdoff_cnt == '0);
        end
    end

endmodule

// File: rtl/xge_wb_regif.sv
// Wishbone slave register block for the 10G MAC: config, interrupt control and clear-on-read statistics.
module xge_wb_regif
    import xge_regif_pkg::*;
#(
    parameter int unsigned NUM_INT   = 10,
    parameter int unsigned NUM_STATS = 4,
    parameter int unsigned STAT_W    = 32,
    parameter int unsigned ADDR_W    = 8,
    parameter logic        CFG_RST   = 1'b1
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic [ADDR_W-1:0]           wb_adr_i,
    input  logic [31:0]                 wb_dat_i,
    input  logic                        wb_we_i,
    input  logic                        wb_stb_i,
    input  logic                        wb_cyc_i,
    output logic [31:0]                 wb_dat_o,
    output logic                        wb_ack_o,
    output logic                        wb_int_o,
    input  logic [NUM_INT-1:0]          int_src_i,
    input  logic [NUM_STATS*STAT_W-1:0] stats_i,
    output logic [NUM_STATS-1:0]        clear_stats_o,
    output logic                        ctrl_tx_enable
);

    logic                 accept;
    logic                 wr_en;
    logic                 rd_en;
    logic [31:0]          adr_w;
    logic [31:0]          rd_data;
    logic [NUM_STATS-1:0] stats_hit;

    logic                 cfg_tx_en;
    logic [NUM_INT-1:0]   int_mask;
    logic [NUM_INT-1:0]   int_edge;
    logic [HOLDOFF_W-1:0] int_holdoff;
    logic [NUM_INT-1:0]   int_pending;
    logic [NUM_INT-1:0]   int_status;
    logic                 w1c_we;
    logic                 unused_bits;

    // Holding ack for one cycle blocks re-acceptance, giving one access per two cycles.
    assign accept = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_en  = accept & wb_we_i;
    assign rd_en  = accept & ~wb_we_i;
    assign adr_w  = 32'({wb_adr_i[ADDR_W-1:2], 2'b00});
    assign w1c_we = wr_en && (adr_w == REG_INT_PENDING);

    assign ctrl_tx_enable = cfg_tx_en;
    assign unused_bits    = ^{wb_adr_i[1:0], wb_dat_i};

    always_comb begin
        rd_data   = '0;
        stats_hit = '0;
        case (adr_w)
            REG_CONFIG0:     rd_data[0]                 = cfg_tx_en;
            REG_INT_PENDING: rd_data[NUM_INT-1:0]       = int_pending;
            REG_INT_STATUS:  rd_data[NUM_INT-1:0]       = int_status;
            REG_INT_MASK:    rd_data[NUM_INT-1:0]       = int_mask;
            REG_INT_EDGE:    rd_data[NUM_INT-1:0]       = int_edge;
            REG_INT_HOLDOFF: rd_data[HOLDOFF_W-1:0]     = int_holdoff;
            REG_VERSION:     rd_data                    = VERSION;
            default: begin
                for (int unsigned i = 0; i < NUM_STATS; i++) begin
                    if (adr_w == REG_STATS_BASE + 32'(4 * i)) begin
                        rd_data[STAT_W-1:0] = stats_i[i*STAT_W +: STAT_W];
                        stats_hit[i]        = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o      <= 1'b0;
            wb_dat_o      <= '0;
            clear_stats_o <= '0;
            cfg_tx_en     <= CFG_RST;
            int_mask      <= '0;
            int_edge      <= '0;
            int_holdoff   <= '0;
        end else begin
            wb_ack_o      <= accept;
            clear_stats_o <= rd_en ? stats_hit : '0;
            if (rd_en)
                wb_dat_o <= rd_data;
            if (wr_en) begin
                case (adr_w)
                    REG_CONFIG0:     cfg_tx_en   <= wb_dat_i[0];
                    REG_INT_MASK:    int_mask    <= wb_dat_i[NUM_INT-1:0];
                    REG_INT_EDGE:    int_edge    <= wb_dat_i[NUM_INT-1:0];
                    REG_INT_HOLDOFF: int_holdoff <= wb_dat_i[HOLDOFF_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    xge_int_ctrl #(
        .NUM_INT(NUM_INT)
    ) u_int_ctrl (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .int_src_i   (int_src_i),
        .int_mask    (int_mask),
        .int_edge    (int_edge),
        .int_holdoff (int_holdoff),
        .w1c_we      (w1c_we),
        .w1c_data    (wb_dat_i[NUM_INT-1:0]),
        .int_pending (int_pending),
        .int_status  (int_status),
        .wb_int_o    (wb_int_o)
    );

endmodule
